// File: rtl/vec_lsu.sv
// Per-thread load/store unit: scalar access or masked vector gather/scatter/strided access
// over a single-beat valid/ready memory port. Optional WAITING watchdog: define LSU_TIMEOUT_EN.
module vec_lsu #(
  parameter int VECTOR_SIZE    = 4,
  parameter int DATA_BITS      = 8,
  parameter int ADDR_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [2:0]                       core_state,
  input  logic                             decoded_mem_read_enable,
  input  logic                             decoded_mem_write_enable,
  input  logic                             decoded_vector_mux,
  input  logic                             decoded_stride_mode,
  input  logic [ADDR_BITS-1:0]             rs,
  input  logic [DATA_BITS-1:0]             rt,
  input  logic [ADDR_BITS-1:0]             stride,
  input  logic [VECTOR_SIZE-1:0]           lane_mask,
  input  logic [VECTOR_SIZE*ADDR_BITS-1:0] v_rs,
  input  logic [VECTOR_SIZE*DATA_BITS-1:0] v_rt,
  output logic                             mem_read_valid,
  output logic [ADDR_BITS-1:0]             mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [DATA_BITS-1:0]             mem_read_data,
  output logic                             mem_write_valid,
  output logic [ADDR_BITS-1:0]             mem_write_address,
  output logic [DATA_BITS-1:0]             mem_write_data,
  input  logic                             mem_write_ready,
  output logic [2:0]                       lsu_state,
  output logic [DATA_BITS-1:0]             lsu_out,
  output logic [VECTOR_SIZE*DATA_BITS-1:0] v_lsu_out,
  output logic                             lsu_error
);

  localparam int LANE_W = $clog2(VECTOR_SIZE);
  localparam int PTR_W  = LANE_W + 1;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REQUESTING = 3'd1,
    WAITING    = 3'd2,
    ADDR_ADD   = 3'd3,
    DONE       = 3'd4
  } state_e;

  state_e                         state_q;
  logic                           is_read_q;
  logic                           is_vec_q;
  logic                           stride_mode_q;
  logic [ADDR_BITS-1:0]           rs_q;
  logic [DATA_BITS-1:0]           rt_q;
  logic [ADDR_BITS-1:0]           stride_q;
  logic [VECTOR_SIZE-1:0]         mask_q;
  logic [VECTOR_SIZE*ADDR_BITS-1:0] v_rs_q;
  logic [VECTOR_SIZE*DATA_BITS-1:0] v_rt_q;
  logic [PTR_W-1:0]               ptr_q;
  logic                           rd_valid_q;
  logic [ADDR_BITS-1:0]           rd_addr_q;
  logic                           wr_valid_q;
  logic [ADDR_BITS-1:0]           wr_addr_q;
  logic [DATA_BITS-1:0]           wr_data_q;
  logic [DATA_BITS-1:0]           lsu_out_q;
  logic [VECTOR_SIZE*DATA_BITS-1:0] v_lsu_out_q;

  logic [LANE_W-1:0]              lane_s;
  logic [ADDR_BITS-1:0]           lane_addr_d;
  logic [DATA_BITS-1:0]           lane_wdata_d;
  logic [PTR_W-1:0]               next_ptr_d;
  logic                           ready_s;

`ifdef LSU_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            lsu_error_q;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES != 0);
`endif

  // Lowest enabled lane at or above 'from'; VECTOR_SIZE when none remains.
  function automatic logic [PTR_W-1:0] next_lane(input logic [VECTOR_SIZE-1:0] m,
                                                 input logic [PTR_W-1:0] from);
    logic [PTR_W-1:0] r;
    r = PTR_W'(VECTOR_SIZE);
    for (int i = VECTOR_SIZE - 1; i >= 0; i--) begin
      if (m[i] && (PTR_W'(i) >= from)) r = PTR_W'(i);
    end
    return r;
  endfunction

  // Current-lane address/data, next enabled lane and qualified handshake.
  always_comb begin
    lane_s       = ptr_q[LANE_W-1:0];
    lane_addr_d  = stride_mode_q ? (rs_q + stride_q * ADDR_BITS'(ptr_q))
                                 : v_rs_q[lane_s*ADDR_BITS +: ADDR_BITS];
    lane_wdata_d = v_rt_q[lane_s*DATA_BITS +: DATA_BITS];
    next_ptr_d   = next_lane(mask_q, ptr_q + PTR_W'(1));
    ready_s      = is_read_q ? (mem_read_ready && rd_valid_q)
                             : (mem_write_ready && wr_valid_q);
  end

  // Sequencer with registered memory-port and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      is_read_q     <= 1'b0;
      is_vec_q      <= 1'b0;
      stride_mode_q <= 1'b0;
      rs_q          <= ADDR_BITS'(0);
      rt_q          <= DATA_BITS'(0);
      stride_q      <= ADDR_BITS'(0);
      mask_q        <= VECTOR_SIZE'(0);
      v_rs_q        <= (VECTOR_SIZE*ADDR_BITS)'(0);
      v_rt_q        <= (VECTOR_SIZE*DATA_BITS)'(0);
      ptr_q         <= PTR_W'(0);
      rd_valid_q    <= 1'b0;
      rd_addr_q     <= ADDR_BITS'(0);
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= ADDR_BITS'(0);
      wr_data_q     <= DATA_BITS'(0);
      lsu_out_q     <= DATA_BITS'(0);
      v_lsu_out_q   <= (VECTOR_SIZE*DATA_BITS)'(0);
`ifdef LSU_TIMEOUT_EN
      to_cnt_q      <= TO_W'(0);
      lsu_error_q   <= 1'b0;
`endif
    end else if (enable) begin
      case (state_q)
        IDLE: begin
          if ((core_state == CORE_REQUEST) &&
              (decoded_mem_read_enable || decoded_mem_write_enable)) begin
            is_read_q     <= decoded_mem_read_enable;
            is_vec_q      <= decoded_vector_mux;
            stride_mode_q <= decoded_stride_mode;
            rs_q          <= rs;
            rt_q          <= rt;
            stride_q      <= stride;
            mask_q        <= lane_mask;
            v_rs_q        <= v_rs;
            v_rt_q        <= v_rt;
            ptr_q         <= next_lane(lane_mask, PTR_W'(0));
            state_q       <= REQUESTING;
          end else begin
            state_q <= IDLE;
          end
        end
        REQUESTING: begin
          if (is_vec_q && (mask_q == VECTOR_SIZE'(0))) begin
            state_q <= DONE;
          end else begin
            if (is_read_q) begin
              rd_valid_q <= 1'b1;
              rd_addr_q  <= is_vec_q ? lane_addr_d : rs_q;
            end else begin
              wr_valid_q <= 1'b1;
              wr_addr_q  <= is_vec_q ? lane_addr_d : rs_q;
              wr_data_q  <= is_vec_q ? lane_wdata_d : rt_q;
            end
`ifdef LSU_TIMEOUT_EN
            to_cnt_q <= TO_W'(0);
`endif
            state_q <= WAITING;
          end
        end
        WAITING: begin
          if (ready_s) begin
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            if (is_read_q && is_vec_q) begin
              v_lsu_out_q[lane_s*DATA_BITS +: DATA_BITS] <= mem_read_data;
            end else if (is_read_q) begin
              lsu_out_q <= mem_read_data;
            end else begin
              lsu_out_q <= lsu_out_q;
            end
            state_q <= is_vec_q ? ADDR_ADD : DONE;
`ifdef LSU_TIMEOUT_EN
          end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // Watchdog abort: remaining lanes are abandoned.
            rd_valid_q  <= 1'b0;
            wr_valid_q  <= 1'b0;
            lsu_error_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
`else
          end else begin
            state_q <= WAITING;
`endif
          end
        end
        ADDR_ADD: begin
          ptr_q   <= next_ptr_d;
          state_q <= (next_ptr_d == PTR_W'(VECTOR_SIZE)) ? DONE : REQUESTING;
        end
        DONE: begin
          if (core_state == CORE_UPDATE) begin
            state_q <= IDLE;
`ifdef LSU_TIMEOUT_EN
            lsu_error_q <= 1'b0;
`endif
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q    <= IDLE;
          rd_valid_q <= 1'b0;
          wr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read_valid    = rd_valid_q;
  assign mem_read_address  = rd_addr_q;
  assign mem_write_valid   = wr_valid_q;
  assign mem_write_address = wr_addr_q;
  assign mem_write_data    = wr_data_q;
  assign lsu_state         = state_q;
  assign lsu_out           = lsu_out_q;
  assign v_lsu_out         = v_lsu_out_q;
`ifdef LSU_TIMEOUT_EN
  assign lsu_error         = lsu_error_q;
`else
  assign lsu_error         = 1'b0;
`endif

endmodule

// File: tb/tb_vec_lsu.sv
// Directed self-checking bench for vec_lsu (4 lanes, 8-bit data/address).
module tb_vec_lsu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [2:0]  core_state = 3'b000;
  logic        rd_en = 1'b0, wr_en = 1'b0, vec = 1'b0, strided = 1'b0;
  logic [7:0]  rs = 8'h00, rt = 8'h00, stride = 8'h00;
  logic [3:0]  lane_mask = 4'h0;
  logic [31:0] v_rs = 32'h0, v_rt = 32'h0;
  logic        mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
  logic [7:0]  mem_read_address, mem_read_data, mem_write_address, mem_write_data;
  logic [2:0]  lsu_state;
  logic [7:0]  lsu_out;
  logic [31:0] v_lsu_out;
  logic        lsu_error;

  logic        auto_ready = 1'b0, rd_ready_man = 1'b0, wr_ready_man = 1'b0;
  logic        use_fixed = 1'b0;
  logic [7:0]  fixed_data = 8'h00;
  logic [7:0]  rd_log[$];
  logic [15:0] wr_log[$];
  logic        valid_seen = 1'b0;
  int          checks = 0, errors = 0, edges;

  localparam logic [2:0] REQ = 3'b011, UPD = 3'b110;

  always #5 clk = ~clk;

  assign mem_read_ready  = auto_ready ? mem_read_valid  : rd_ready_man;
  assign mem_write_ready = auto_ready ? mem_write_valid : wr_ready_man;
  assign mem_read_data   = use_fixed ? fixed_data : mem_read_address + 8'h01;

  always @(posedge clk) begin
    if (enable && mem_read_valid && mem_read_ready) rd_log.push_back(mem_read_address);
    if (enable && mem_write_valid && mem_write_ready) wr_log.push_back({mem_write_address, mem_write_data});
    if (mem_read_valid || mem_write_valid) valid_seen <= 1'b1;
  end

  vec_lsu #(.VECTOR_SIZE(4), .DATA_BITS(8), .ADDR_BITS(8), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
    .decoded_vector_mux(vec), .decoded_stride_mode(strided),
    .rs(rs), .rt(rt), .stride(stride), .lane_mask(lane_mask), .v_rs(v_rs), .v_rt(v_rt),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .lsu_state(lsu_state), .lsu_out(lsu_out), .v_lsu_out(v_lsu_out), .lsu_error(lsu_error));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a REQUEST for one cycle (edge 1), then withdraws the decode.
  task automatic issue(input logic r, input logic w, input logic v, input logic s);
    rd_en = r; wr_en = w; vec = v; strided = s; core_state = REQ;
    step();
    core_state = 3'b000; rd_en = 1'b0; wr_en = 1'b0;
    edges = 1;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 60 && lsu_state != 3'd4; n++) begin
      step();
      edges++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if (lsu_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", lsu_state); end
    checks++; if ({mem_read_valid, mem_write_valid, lsu_error} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {mem_read_valid, mem_write_valid, lsu_error}); end
    checks++; if ({lsu_out, v_lsu_out} !== 40'h0) begin errors++; $display("FAIL reset_data got %h want 0", {lsu_out, v_lsu_out}); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_scalar_load();
    rd_log.delete(); use_fixed = 1'b1; fixed_data = 8'hA5; auto_ready = 1'b0; rd_ready_man = 1'b0;
    rs = 8'h10;
    issue(1'b1, 1'b0, 1'b0, 1'b0);
    rs = 8'h55;
    checks++; if (lsu_state !== 3'd1) begin errors++; $display("FAIL scalar_req got %0d want 1", lsu_state); end
    step(); step(); step();
    checks++; if (lsu_state !== 3'd2 || mem_read_valid !== 1'b1 || mem_read_address !== 8'h10) begin errors++; $display("FAIL scalar_hold got st=%0d v=%b a=%h want 2 1 10", lsu_state, mem_read_valid, mem_read_address); end
    rd_ready_man = 1'b1;
    step();
    rd_ready_man = 1'b0;
    checks++; if (lsu_state !== 3'd4 || mem_read_valid !== 1'b0 || lsu_out !== 8'hA5) begin errors++; $display("FAIL scalar_done got st=%0d v=%b d=%h want 4 0 a5", lsu_state, mem_read_valid, lsu_out); end
    step(); step();
    checks++; if (lsu_state !== 3'd4) begin errors++; $display("FAIL scalar_hold_done got %0d want 4", lsu_state); end
    core_state = UPD; step(); core_state = 3'b000;
    checks++; if (lsu_state !== 3'd0 || rd_log.size() != 1) begin errors++; $display("FAIL scalar_idle got st=%0d reads=%0d want 0 1", lsu_state, rd_log.size()); end
    use_fixed = 1'b0;
  endtask

  task automatic test_read_wins();
    rd_log.delete(); wr_log.delete(); auto_ready = 1'b1;
    rs = 8'h20; rt = 8'h77;
    issue(1'b1, 1'b1, 1'b0, 1'b0);
    wait_done();
    checks++; if (edges != 3) begin errors++; $display("FAIL scalar_latency got %0d want 3", edges); end
    checks++; if (rd_log.size() != 1 || wr_log.size() != 0 || lsu_out !== 8'h21) begin errors++; $display("FAIL read_wins got r=%0d w=%0d d=%h want 1 0 21", rd_log.size(), wr_log.size(), lsu_out); end
    core_state = UPD; step(); core_state = 3'b000;
  endtask

  task automatic test_gather_load();
    logic [7:0] exp_addr[4];
    exp_addr = '{8'h00, 8'h01, 8'h02, 8'h03};
    rd_log.delete(); auto_ready = 1'b1;
    v_rs = 32'h03020100; lane_mask = 4'b1111;
    issue(1'b1, 1'b0, 1'b1, 1'b0);
    wait_done();
    checks++; if (edges != 13) begin errors++; $display("FAIL gather_latency got %0d want 13", edges); end
    checks++; if (rd_log.size() != 4) begin errors++; $display("FAIL gather_count got %0d want 4", rd_log.size()); end
    for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
      checks++; if (rd_log[i] !== exp_addr[i]) begin errors++; $display("FAIL gather_addr%0d got %h want %h", i, rd_log[i], exp_addr[i]); end
    end
    checks++; if (v_lsu_out !== 32'h04030201) begin errors++; $display("FAIL gather_data got %h want 04030201", v_lsu_out); end
    core_state = UPD; step(); core_state = 3'b000;
  endtask

  task automatic test_strided_store();
    logic [15:0] exp_wr[3];
    exp_wr = '{16'hFEAA, 16'h00BB, 16'h04DD};
    wr_log.delete(); auto_ready = 1'b1;
    rs = 8'hFE; stride = 8'h02; lane_mask = 4'b1011; v_rt = 32'hDDCCBBAA;
    issue(1'b0, 1'b1, 1'b1, 1'b1);
    wait_done();
    checks++; if (edges != 10) begin errors++; $display("FAIL strided_latency got %0d want 10", edges); end
    checks++; if (wr_log.size() != 3) begin errors++; $display("FAIL strided_count got %0d want 3", wr_log.size()); end
    for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
      checks++; if (wr_log[i] !== exp_wr[i]) begin errors++; $display("FAIL strided_wr%0d got %h want %h", i, wr_log[i], exp_wr[i]); end
    end
    checks++; if (v_lsu_out !== 32'h04030201) begin errors++; $display("FAIL strided_vout got %h want 04030201", v_lsu_out); end
    core_state = UPD; step(); core_state = 3'b000;
  endtask

  task automatic test_mask_zero();
    valid_seen = 1'b0; auto_ready = 1'b1;
    lane_mask = 4'b0000; v_rs = 32'h44332211;
    issue(1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (lsu_state !== 3'd1) begin errors++; $display("FAIL mask0_req got %0d want 1", lsu_state); end
    step();
    checks++; if (lsu_state !== 3'd4 || valid_seen !== 1'b0) begin errors++; $display("FAIL mask0_done got st=%0d seen=%b want 4 0", lsu_state, valid_seen); end
    checks++; if (v_lsu_out !== 32'h04030201) begin errors++; $display("FAIL mask0_vout got %h want 04030201", v_lsu_out); end
    core_state = UPD; step(); core_state = 3'b000;
  endtask

  task automatic test_reset_mid();
    auto_ready = 1'b0; rd_ready_man = 1'b0;
    v_rs = 32'h13121110; lane_mask = 4'b1111;
    issue(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    rd_ready_man = 1'b1; step(); rd_ready_man = 1'b0;
    step(); step();
    checks++; if (lsu_state !== 3'd2 || mem_read_address !== 8'h11 || mem_read_valid !== 1'b1) begin errors++; $display("FAIL lane1_wait got st=%0d a=%h v=%b want 2 11 1", lsu_state, mem_read_address, mem_read_valid); end
    reset = 1'b1; #1;
    checks++; if (mem_read_valid !== 1'b0 || lsu_state !== 3'd0 || v_lsu_out !== 32'h0 || lsu_out !== 8'h0) begin errors++; $display("FAIL async_reset got v=%b st=%0d vo=%h o=%h want 0 0 0 0", mem_read_valid, lsu_state, v_lsu_out, lsu_out); end
    step(); reset = 1'b0; step();
    checks++; if (lsu_state !== 3'd0 || mem_read_valid !== 1'b0) begin errors++; $display("FAIL no_resume got st=%0d v=%b want 0 0", lsu_state, mem_read_valid); end
  endtask

  task automatic test_enable_freeze();
    rd_log.delete(); auto_ready = 1'b0; rd_ready_man = 1'b0;
    v_rs = 32'h33323130; lane_mask = 4'b0101;
    issue(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    enable = 1'b0; rd_ready_man = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (lsu_state !== 3'd2 || mem_read_valid !== 1'b1 || mem_read_address !== 8'h30 || v_lsu_out !== 32'h0) begin errors++; $display("FAIL frozen got st=%0d v=%b a=%h vo=%h want 2 1 30 0", lsu_state, mem_read_valid, mem_read_address, v_lsu_out); end
    enable = 1'b1; rd_ready_man = 1'b0; auto_ready = 1'b1;
    wait_done();
    checks++; if (lsu_state !== 3'd4 || v_lsu_out !== 32'h00330031) begin errors++; $display("FAIL resume got st=%0d vo=%h want 4 00330031", lsu_state, v_lsu_out); end
    checks++; if (rd_log.size() != 2) begin errors++; $display("FAIL resume_reads got %0d want 2", rd_log.size()); end
    core_state = UPD; step(); core_state = 3'b000;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    auto_ready = 1'b0; wr_ready_man = 1'b0;
    rs = 8'h40; rt = 8'h99;
    issue(1'b0, 1'b1, 1'b0, 1'b0);
    step(); step(); step(); step();
    checks++; if (lsu_state !== 3'd2 || mem_write_valid !== 1'b1) begin errors++; $display("FAIL to_wait got st=%0d v=%b want 2 1", lsu_state, mem_write_valid); end
    step();
    checks++; if (lsu_state !== 3'd4 || mem_write_valid !== 1'b0 || lsu_error !== 1'b1) begin errors++; $display("FAIL to_abort got st=%0d v=%b e=%b want 4 0 1", lsu_state, mem_write_valid, lsu_error); end
    core_state = UPD; step(); core_state = 3'b000;
    checks++; if (lsu_state !== 3'd0 || lsu_error !== 1'b0) begin errors++; $display("FAIL to_clear got st=%0d e=%b want 0 0", lsu_state, lsu_error); end
  endtask
`else
  task automatic test_no_timeout();
    wr_log.delete(); auto_ready = 1'b0; wr_ready_man = 1'b0;
    rs = 8'h40; rt = 8'h99;
    issue(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    checks++; if (lsu_state !== 3'd2 || mem_write_valid !== 1'b1 || lsu_error !== 1'b0) begin errors++; $display("FAIL long_wait got st=%0d v=%b e=%b want 2 1 0", lsu_state, mem_write_valid, lsu_error); end
    wr_ready_man = 1'b1; step(); wr_ready_man = 1'b0;
    checks++; if (lsu_state !== 3'd4 || wr_log.size() != 1 || (wr_log.size() == 1 && wr_log[0] !== 16'h4099)) begin errors++; $display("FAIL late_write got st=%0d n=%0d want 4 1 (4099)", lsu_state, wr_log.size()); end
    core_state = UPD; step(); core_state = 3'b000;
  endtask
`endif

  initial begin
    test_reset();
    test_scalar_load();
    test_read_wins();
    test_gather_load();
    test_strided_store();
    test_mask_zero();
    test_reset_mid();
    test_enable_freeze();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/vec_lsu.md
Name: vec_lsu

Overview:
- Parametrised successor to the core's per-thread load/store unit.
- Executes one scalar load/store, or one vector load/store of VECTOR_SIZE lanes per instruction, over a single-beat valid/ready data-memory port.
- Vector modes: gather/scatter (per-lane addresses from v_rs) and strided (rs + lane*stride), with per-lane masking.
- Sits between the thread's register files and the data-memory arbiter; sequenced by core_state.

Parameters:
- VECTOR_SIZE, 4, number of vector lanes (>=2).
- DATA_BITS, 8, width of one data element.
- ADDR_BITS, 8, memory address width.
- TIMEOUT_CYCLES, 255, WAITING watchdog limit; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- enable  in  1  thread active; low freezes all state and outputs.
- core_state  in  3  core sequencer state; REQUEST=3'b011, UPDATE=3'b110.
- decoded_mem_read_enable  in  1  load instruction.
- decoded_mem_write_enable  in  1  store instruction.
- decoded_vector_mux  in  1  1 = vector op, 0 = scalar op.
- decoded_stride_mode  in  1  vector only: 1 = strided, 0 = gather/scatter.
- rs  in  ADDR_BITS  scalar address, or strided base.
- rt  in  DATA_BITS  scalar store data.
- stride  in  ADDR_BITS  strided-mode lane increment.
- lane_mask  in  VECTOR_SIZE  bit i = 1 enables lane i.
- v_rs  in  VECTOR_SIZE*ADDR_BITS  per-lane addresses; lane i at [i*ADDR_BITS +: ADDR_BITS].
- v_rt  in  VECTOR_SIZE*DATA_BITS  per-lane store data.
- mem_read_valid  out  1 / mem_read_address  out  ADDR_BITS / mem_read_ready  in  1 / mem_read_data  in  DATA_BITS.
- mem_write_valid  out  1 / mem_write_address  out  ADDR_BITS / mem_write_data  out  DATA_BITS / mem_write_ready  in  1.
- lsu_state  out  3  IDLE=0, REQUESTING=1, WAITING=2, ADDR_ADD=3, DONE=4.
- lsu_out  out  DATA_BITS  scalar load result.
- v_lsu_out  out  VECTOR_SIZE*DATA_BITS  vector load result.
- lsu_error  out  1  watchdog abort flag.

Behaviour:
- Reset (async): all outputs 0, including lsu_state=IDLE, v_lsu_out=0; lane pointer 0. Any in-flight valid drops immediately; no transaction is resumed.
- enable=0: no state change; all registers hold.

State machine:
- IDLE: if core_state==REQUEST and (read or write enabled), go to REQUESTING. In that same cycle, latch rs, rt, stride, lane_mask, v_rs, v_rt and the op mode; later input changes have no effect. If read and write are both enabled, read wins and the write is ignored. If neither is enabled, stay IDLE.
- REQUESTING, scalar: drive the latched address (and rt on store), set the matching valid to 1, go to WAITING.
- REQUESTING, vector: the lane pointer sits on the lowest enabled lane. Issue that lane, go to WAITING. Lane address is v_rs lane, or rs + lane*stride truncated mod 2^ADDR_BITS. If the latched mask is all zeros, go to DONE with no memory transaction.
- WAITING: valid, address and data are held stable until ready is sampled high.
  - On ready: clear valid next edge. Loads capture mem_read_data into lsu_out, or into the current v_lsu_out lane.
  - Scalar goes to DONE; vector goes to ADDR_ADD.
  - Ready while the matching valid is low is ignored.
- ADDR_ADD: advance the pointer to the next enabled lane and return to REQUESTING. If no enabled lane remains, go to DONE.
- DONE: hold until core_state==UPDATE, then go to IDLE.
- Masked lanes: never accessed; their v_lsu_out lanes keep their previous value.
- Lane pointer is $clog2(VECTOR_SIZE)+1 bits wide; no wrap past lane VECTOR_SIZE-1.

Latency, ready returned the same cycle valid rises:
- Scalar: DONE 3 edges after the REQUEST cycle.
- Vector: DONE 1 + 3*N edges after the REQUEST cycle, for N enabled lanes.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: a counter runs in WAITING. If ready is still low after TIMEOUT_CYCLES cycles, drop valid, set lsu_error=1 and go to DONE, skipping the remaining lanes. lsu_error clears on the DONE->IDLE transition.
- Undefined: no counter; lsu_error is tied 0; WAITING waits indefinitely.

Test Plan:
- Scalar load, rs=8'h10, memory returns 8'hA5 after 2 wait cycles -> mem_read_address=8'h10 with valid held 3 cycles, lsu_out=8'hA5, DONE until UPDATE, then IDLE.
- Vector gather load, v_rs={8'h03,8'h02,8'h01,8'h00}, mask=4'b1111, zero-wait memory returning addr+1 -> 4 reads in lane order, v_lsu_out=32'h04030201, DONE 13 edges after REQUEST.
- Strided store, rs=8'hFE, stride=2, mask=4'b1011, v_rt=32'hDDCCBBAA -> writes (FE,AA), (00,BB), (04,DD); lane 2 skipped; address wraps.
- mask=4'b0000 vector load -> no valid ever asserted; IDLE->REQUESTING->DONE; v_lsu_out unchanged.
- Assert reset in WAITING of lane 1 -> valid low immediately, all outputs 0, IDLE. Also hold enable=0 for 5 cycles mid-op -> state and outputs frozen, then resume correctly.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, never assert ready -> valid drops after 4 WAITING cycles, lsu_error=1, DONE; error clears on UPDATE.
